// File: rtl/audio_out_serializer.sv
// Mono I2S transmitter: offset-binary to two's complement conversion, BCLK/LRCLK
// generation, hold-and-repeat on upstream underrun with a saturating underrun count.
module audio_out_serializer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] sample_in,
    input  logic        sample_valid,
    input  logic        mute,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        sample_taken,
    output logic [7:0]  underrun_count
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div;
    logic [5:0]  bit_cnt;
    logic [19:0] hold_reg;
    logic [19:0] frame_reg;
    logic        pending;

    logic        tick;
    logic        fall_evt;
    logic        frame_load;
    logic [5:0]  bit_cnt_nxt;
    logic [4:0]  slot_k;
    logic        sdata_nxt;

    always_comb begin
        tick        = (div == DIV_LAST);
        fall_evt    = tick && bclk;
        frame_load  = fall_evt && (bit_cnt == 6'd63);
        bit_cnt_nxt = bit_cnt + 6'd1;
        slot_k      = bit_cnt_nxt[4:0];
        // Serial data is registered from the upcoming slot position, so k=0 gives the I2S delay bit.
        sdata_nxt   = 1'b0;
        if (slot_k >= 5'd1 && slot_k <= 5'd20) begin
            sdata_nxt = frame_reg[5'd20 - slot_k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
        end else begin
            div <= tick ? 8'd0 : div + 8'd1;
            if (tick) begin
                bclk <= ~bclk;
            end
            if (fall_evt) begin
                bit_cnt <= bit_cnt_nxt;
                lrclk   <= bit_cnt_nxt[5];
                sdata   <= sdata_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg       <= '0;
            pending        <= 1'b0;
            frame_reg      <= '0;
            frame_start    <= 1'b0;
            sample_taken   <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_start  <= frame_load;
            sample_taken <= frame_load && pending;
            if (frame_load) begin
                frame_reg <= mute ? 20'h00000 : hold_reg;
                if (!pending && underrun_count != 8'hFF) begin
                    underrun_count <= underrun_count + 8'd1;
                end
            end
            // A sample arriving on the load cycle wins over the clear and is kept for the next frame.
            if (sample_valid) begin
                hold_reg <= {~sample_in[19], sample_in[18:0]};
                pending  <= 1'b1;
            end else if (frame_load) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_out_serializer.sv
// Scoreboard bench for audio_out_serializer: per-frame expectations are queued by the
// driver and checked by a monitor that reassembles each serial frame at BCLK rising edges.
module tb_audio_out_serializer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FRAME   = 128 * CLK_DIV;

    typedef struct {
        logic [19:0] frame;
        logic        taken;
        logic [7:0]  under;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] sample_in;
    logic        sample_valid;
    logic        mute;
    logic        bclk, lrclk, sdata, frame_start, sample_taken;
    logic [7:0]  underrun_count;

    logic        reset_sat;
    logic [19:0] sample_in_sat;
    logic        sample_valid_sat;
    logic        mute_sat;
    logic        bclk_sat, lrclk_sat, sdata_sat, frame_start_sat, sample_taken_sat;
    logic [7:0]  underrun_count_sat;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    rec_t        sb[$];
    bit          drv_done = 1'b0;
    bit          mon_done = 1'b0;
    bit          sat_done = 1'b0;

    logic [19:0] m_hold    = '0;
    logic        m_pending = 1'b0;
    logic [7:0]  m_under   = '0;

    audio_out_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .mute(mute), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .sample_taken(sample_taken), .underrun_count(underrun_count)
    );

    audio_out_serializer #(.CLK_DIV(1)) dut_sat (
        .clk(clk), .reset(reset_sat), .sample_in(sample_in_sat), .sample_valid(sample_valid_sat),
        .mute(mute_sat), .bclk(bclk_sat), .lrclk(lrclk_sat), .sdata(sdata_sat),
        .frame_start(frame_start_sat), .sample_taken(sample_taken_sat),
        .underrun_count(underrun_count_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] conv(input logic [19:0] s);
        return {~s[19], s[18:0]};
    endfunction

    function automatic logic [63:0] exp_bits(input logic [19:0] f);
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            int unsigned k = i % 32;
            if (k >= 1 && k <= 20) v[i] = f[20 - k];
        end
        return v;
    endfunction

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // One frame-load period: optional mid-frame sample, optional sample on the load cycle itself.
    task automatic run_load(input int unsigned n, input bit give, input logic [19:0] s,
                            input bit col, input logic [19:0] cs, input logic m);
        int unsigned base = (n - 1) * FRAME;
        rec_t r;
        wait_cyc(base + 5);
        mute = m;
        if (give) begin
            wait_cyc(base + 19);
            sample_in = s; sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            m_hold = conv(s); m_pending = 1'b1;
        end
        r.frame = m ? 20'h00000 : m_hold;
        r.taken = m_pending;
        if (!m_pending && m_under != 8'hFF) m_under = m_under + 8'd1;
        r.under = m_under;
        m_pending = 1'b0;
        sb.push_back(r);
        if (col) begin
            wait_cyc(n * FRAME - 1);
            sample_in = cs; sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            m_hold = conv(cs); m_pending = 1'b1;
        end
    endtask

    task automatic check_startup(input logic [7:0] exp_under, input logic exp_taken, input string tag);
        int unsigned first_b = 0, first_l = 0, first_f = 0;
        logic saw_sd = 1'b0;
        logic [7:0] got_under = '0;
        logic got_taken = 1'b0;
        for (int unsigned i = 0; i < FRAME + 16 && first_f == 0; i++) begin
            @(negedge clk);
            if (bclk === 1'b1 && first_b == 0) first_b = cyc;
            if (lrclk === 1'b1 && first_l == 0) first_l = cyc;
            if (frame_start === 1'b1) begin
                first_f = cyc; got_under = underrun_count; got_taken = sample_taken;
            end else if (sdata !== 1'b0) saw_sd = 1'b1;
        end
        chk({tag, "_bclk_first_rise"}, 64'(first_b), 64'(CLK_DIV));
        chk({tag, "_lrclk_first_rise"}, 64'(first_l), 64'(64 * CLK_DIV));
        chk({tag, "_frame_start_first"}, 64'(first_f), 64'(FRAME));
        chk({tag, "_sdata_quiet"}, 64'(saw_sd), 64'd0);
        chk({tag, "_first_underrun"}, 64'(got_under), 64'(exp_under));
        chk({tag, "_first_taken"}, 64'(got_taken), 64'(exp_taken));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bclk"}, 64'(bclk), 64'd0);
        chk({tag, "_lrclk"}, 64'(lrclk), 64'd0);
        chk({tag, "_sdata"}, 64'(sdata), 64'd0);
        chk({tag, "_frame_start"}, 64'(frame_start), 64'd0);
        chk({tag, "_sample_taken"}, 64'(sample_taken), 64'd0);
        chk({tag, "_underrun"}, 64'(underrun_count), 64'd0);
    endtask

    // Monitor: pops one record per frame_start and reassembles the 64 slot bits.
    initial begin : monitor
        rec_t r;
        logic [63:0] gd, gl;
        logic prev;
        int unsigned w, cnt;
        while (!(drv_done && sb.size() == 0)) begin
            w = 0;
            do begin @(negedge clk); w++; end while (frame_start !== 1'b1 && w < 2 * FRAME);
            if (frame_start !== 1'b1) begin
                chk("frame_start_timeout", 64'd0, 64'd1);
                break;
            end
            if (sb.size() == 0) begin
                chk("unexpected_frame", 64'd1, 64'd0);
                break;
            end
            r = sb.pop_front();
            chk("sample_taken", 64'(sample_taken), 64'(r.taken));
            chk("underrun_count", 64'(underrun_count), 64'(r.under));
            gd = '0; gl = '0; prev = bclk; cnt = 0; w = 0;
            while (cnt < 64 && w < FRAME) begin
                @(negedge clk);
                w++;
                if (w == 1) chk("pulse_width", 64'({frame_start, sample_taken}), 64'd0);
                if (bclk === 1'b1 && prev === 1'b0) begin
                    gd[cnt] = sdata; gl[cnt] = lrclk; cnt++;
                end
                prev = bclk;
            end
            chk("slot_data", gd, exp_bits(r.frame));
            chk("lrclk_slots", gl, 64'hFFFF_FFFF_0000_0000);
        end
        mon_done = 1'b1;
    end

    // Saturation run on a fast instance: 300 frames with no samples.
    initial begin : saturation
        int unsigned w;
        reset_sat = 1'b1; sample_in_sat = '0; sample_valid_sat = 1'b0; mute_sat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_sat = 1'b0;
        for (int unsigned n = 1; n <= 300; n++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (frame_start_sat !== 1'b1 && w < 140);
            if (frame_start_sat !== 1'b1) begin
                chk("sat_frame_timeout", 64'd0, 64'd1);
                break;
            end
            chk("sat_underrun", 64'(underrun_count_sat), (n > 255) ? 64'd255 : 64'(n));
        end
        sat_done = 1'b1;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        reset = 1'b1; sample_in = '0; sample_valid = 1'b0; mute = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        fork
            check_startup(8'd0, 1'b1, "boot");
            begin
                run_load(1,  1, 20'hFFFFF, 0, 20'h0,     1'b0);
                run_load(2,  1, 20'h80000, 0, 20'h0,     1'b0);
                run_load(3,  1, 20'h00000, 0, 20'h0,     1'b0);
                run_load(4,  0, 20'h0,     0, 20'h0,     1'b0);
                run_load(5,  0, 20'h0,     0, 20'h0,     1'b0);
                run_load(6,  0, 20'h0,     0, 20'h0,     1'b0);
                run_load(7,  1, 20'hABCDE, 1, 20'h12345, 1'b0);
                run_load(8,  0, 20'h0,     0, 20'h0,     1'b0);
                run_load(9,  0, 20'h0,     1, 20'h55555, 1'b0);
                run_load(10, 0, 20'h0,     0, 20'h0,     1'b0);
                run_load(11, 1, 20'hFFFFF, 0, 20'h0,     1'b1);
                run_load(12, 0, 20'h0,     0, 20'h0,     1'b1);
                run_load(13, 0, 20'h0,     0, 20'h0,     1'b0);
                drv_done = 1'b1;
            end
        join
        // Frame 14 is an underrun repeating 7FFFF; reset when bit_cnt has just reached 17.
        wait_cyc(14 * FRAME + 17 * 2 * CLK_DIV);
        chk("pre_reset_underrun", 64'(underrun_count), 64'd7);
        chk("pre_reset_sdata", 64'(sdata), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        check_startup(8'd1, 1'b0, "restart");
        wait (sat_done && mon_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_out_serializer.md
# audio_out_serializer

Mono I2S transmitter sitting directly downstream of the envelope stage. It takes the 20-bit enveloped sample, converts it from offset-binary to two's complement, and shifts it out once per frame on both left and right I2S slots. The block generates the DAC bit clock and word clock from the system clock. It tolerates an upstream sample rate that does not match the frame rate by holding and repeating the last sample, and it counts underruns.

## Interface
Parameters:
- CLK_DIV, default 4: system clocks per BCLK half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  20  enveloped sample, offset-binary, 20'h80000 = midscale.
- sample_valid  in  1  one-cycle or level strobe; sample_in captured every cycle it is high.
- mute  in  1  forces silence from the next frame load.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left slot, 1 = right slot.
- sdata  out  1  I2S serial data, MSB first.
- frame_start  out  1  one-cycle pulse on the frame-load cycle.
- sample_taken  out  1  one-cycle pulse on frame load when a fresh sample was consumed.
- underrun_count  out  8  saturating count of frame loads with no fresh sample.

## Operation
- Clock divider:
  - div counts 0..CLK_DIV-1.
  - When div = CLK_DIV-1, bclk toggles and div returns to 0.
  - BCLK period is 2*CLK_DIV clk cycles.
- Bit counter:
  - bit_cnt is 6 bits, 0..63.
  - It advances only on the falling-edge event (the cycle in which bclk toggles 1->0), wrapping 63->0.
- lrclk = bit_cnt[5]. It is registered and changes on the same falling-edge event.
- Slot bit k = bit_cnt[4:0]:
  - k=0: sdata=0 (one-BCLK I2S delay).
  - k=1..20: sdata = frame_reg[20-k], so MSB first.
  - k=21..31: sdata=0.
  - Both slots carry the same frame_reg (mono).
- Holding register:
  - Every cycle with sample_valid=1: hold_reg <= {~sample_in[19], sample_in[18:0]} and pending <= 1.
- Frame load, on the falling-edge event where bit_cnt wraps 63->0:
  - frame_reg <= mute ? 20'h00000 : hold_reg, using the hold_reg value from before this cycle.
  - frame_start = 1 for that cycle.
  - If pending=1: sample_taken = 1 for that cycle and pending is cleared.
  - If pending=0: frame_reg repeats the held value and underrun_count increments, saturating at 8'hFF.
- Simultaneous sample_valid and frame load:
  - The load uses the old hold_reg.
  - The new sample updates hold_reg and pending stays 1, so it is consumed at the next frame.
  - If pending was 0 before that cycle, the load still counts as an underrun.
- mute does not affect hold_reg or pending. Muted loads still consume samples and still count underruns.

## Timing
- Reset values:
  - bclk=0, lrclk=0, sdata=0, frame_start=0, sample_taken=0, underrun_count=0.
  - div=0, bit_cnt=0, hold_reg=0, frame_reg=0, pending=0.
- Reset mid-frame returns every register to the reset values on the next edge. Serial output restarts from bit_cnt=0 with a zero frame.
- After reset, the first bclk rising event occurs at cycle CLK_DIV and the first falling event at cycle 2*CLK_DIV.
- The first frame load occurs after 64 falling events, at cycle 128*CLK_DIV after reset release.
- sdata, lrclk and bclk are registered and change only on bclk falling-edge events, except bclk itself. The DAC samples sdata on bclk rising edges.
- Frame period is 128*CLK_DIV clk cycles. Sample-to-first-output latency is at most one frame plus 2 BCLK periods.
- frame_start and sample_taken are registered pulses asserted exactly one clk cycle.

## Test plan
- Reset check: hold reset 3 cycles -> all outputs 0. With CLK_DIV=4, bclk first rises at cycle 4, lrclk first rises at cycle 256, frame_start first pulses at cycle 512.
- Full-scale sample: sample_in=20'hFFFFF pulsed once before the first load -> every slot after that load shows k=0 '0', k=1 '0', k=2..20 '1', k=21..31 '0' on both lrclk levels; sample_taken pulses once.
- Midscale and extremes: 20'h80000 -> all-zero slot data; 20'h00000 -> slot k=1 '1', k=2..20 '0'.
- Underrun: no sample_valid for 3 frames -> underrun_count = 3 and the previous frame data repeats. Drive 300 empty frames -> count holds at 8'hFF.
- Collision: sample_valid with 20'h12345 in the exact frame-load cycle, pending=1 holding 20'hABCDE -> this frame transmits the conversion of 20'hABCDE, the next frame transmits the conversion of 20'h12345, and underrun_count is unchanged.
- Mute and mid-frame reset: mute=1 with pending 20'hFFFFF -> slot data all zero and sample_taken=1. Assert reset at bit_cnt=17 -> outputs zero next cycle and the frame restarts from bit_cnt=0.
